// File: rtl/routing_table_cfg.sv
// rtl/routing_table_cfg.sv - programmable per-node NoC routing table with XY/YX self-fill
// Fills itself with dimension-ordered routes after reset, then serves multi-port lookups and single-entry writes.
module routing_table_cfg #(
  parameter int NODE_ID      = 0,
  parameter int COLS         = 4,
  parameter int ROWS         = 4,
  parameter int ADDR_BITS    = 4,
  parameter int BITS_DIR     = 3,
  parameter int LOOKUP_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              init_req,
  input  logic                              init_mode,
  output logic                              busy,
  input  logic                              cfg_we,
  input  logic [ADDR_BITS-1:0]              cfg_addr,
  input  logic [BITS_DIR-1:0]               cfg_data,
  output logic                              cfg_err,
  input  logic [LOOKUP_PORTS-1:0]           lk_valid,
  input  logic [LOOKUP_PORTS*ADDR_BITS-1:0] lk_addr,
  output logic                              lk_ready,
  output logic [LOOKUP_PORTS-1:0]           rsp_valid,
  output logic [LOOKUP_PORTS*BITS_DIR-1:0]  rsp_dir,
  output logic [LOOKUP_PORTS-1:0]           rsp_err
);

  localparam int NUM_NODES = ROWS * COLS;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int NODE_ROW  = NODE_ID / COLS;
  localparam int NODE_COL  = NODE_ID % COLS;

  localparam logic [BITS_DIR-1:0]  DIR_N = BITS_DIR'(0);
  localparam logic [BITS_DIR-1:0]  DIR_E = BITS_DIR'(1);
  localparam logic [BITS_DIR-1:0]  DIR_S = BITS_DIR'(2);
  localparam logic [BITS_DIR-1:0]  DIR_W = BITS_DIR'(3);
  localparam logic [BITS_DIR-1:0]  DIR_L = BITS_DIR'(4);
  localparam logic [ADDR_BITS-1:0] LAST  = ADDR_BITS'(NUM_NODES - 1);
  localparam logic [ADDR_BITS:0]   NODES = (ADDR_BITS + 1)'(NUM_NODES);

  typedef enum logic {FILL, RUN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   tbl_we;
  logic [ADDR_BITS-1:0]   tbl_waddr;
  logic [BITS_DIR-1:0]    tbl_wdata;
  logic                   cfg_ok;
  logic [LOOKUP_PORTS-1:0]          rsp_valid_q;
  logic [LOOKUP_PORTS*BITS_DIR-1:0] rsp_dir_q;
  logic [LOOKUP_PORTS-1:0]          rsp_err_q;
  logic [BITS_DIR-1:0]    tbl_q [DEPTH];

  // Dimension-ordered route from this node; yx=1 resolves the row first.
  function automatic logic [BITS_DIR-1:0] route(input logic [ADDR_BITS-1:0] dest, input logic yx);
    int d, dr, dc;
    logic [BITS_DIR-1:0] dir_h, dir_v;
    d     = int'(dest);
    dr    = d / COLS;
    dc    = d % COLS;
    dir_h = (dc > NODE_COL) ? DIR_E : DIR_W;
    dir_v = (dr > NODE_ROW) ? DIR_S : DIR_N;
    if (d == NODE_ID) return DIR_L;
    if (yx) return (dr != NODE_ROW) ? dir_v : dir_h;
    return (dc != NODE_COL) ? dir_h : dir_v;
  endfunction

  assign busy     = (state_q == FILL);
  assign lk_ready = ~busy;
  assign cfg_ok   = ({1'b0, cfg_addr} < NODES) && (cfg_data <= DIR_L);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    cfg_err_d = 1'b0;
    tbl_we    = 1'b0;
    tbl_waddr = cfg_addr;
    tbl_wdata = cfg_data;
    case (state_q)
      FILL: begin
        tbl_we    = 1'b1;
        tbl_waddr = cnt_q;
        tbl_wdata = route(cnt_q, mode_q);
        cfg_err_d = cfg_we;
        if (init_req) begin
          cnt_d  = '0;
          mode_d = init_mode;
        end else if (cnt_q == LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      RUN: begin
        // A restart wins over a concurrent write, which is then reported as rejected.
        if (init_req) begin
          state_d   = FILL;
          cnt_d     = '0;
          mode_d    = init_mode;
          cfg_err_d = cfg_we;
        end else if (cfg_we) begin
          if (cfg_ok) tbl_we = 1'b1;
          else        cfg_err_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  // Reads see the table before this edge's write lands (read-before-write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_dir_q   <= '0;
      rsp_err_q   <= '0;
    end else begin
      for (int p = 0; p < LOOKUP_PORTS; p++) begin
        rsp_valid_q[p] <= lk_valid[p] & lk_ready;
        if (lk_valid[p] && lk_ready) begin
          if ({1'b0, lk_addr[p*ADDR_BITS +: ADDR_BITS]} < NODES) begin
            rsp_dir_q[p*BITS_DIR +: BITS_DIR] <= tbl_q[lk_addr[p*ADDR_BITS +: ADDR_BITS]];
            rsp_err_q[p]                      <= 1'b0;
          end else begin
            rsp_dir_q[p*BITS_DIR +: BITS_DIR] <= DIR_L;
            rsp_err_q[p]                      <= 1'b1;
          end
        end
      end
    end
  end

  assign cfg_err   = cfg_err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dir   = rsp_dir_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_routing_table_cfg.sv
// tb/tb_routing_table_cfg.sv - directed scoreboard bench for routing_table_cfg
// Main instance is node 5 of a 4x4 mesh; a second node-5 instance on a 3x4 mesh covers out-of-range lookups.
module tb_routing_table_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_req, init_mode, cfg_we;
  logic [3:0] cfg_addr;
  logic [2:0] cfg_data;
  logic [1:0] lk_valid;
  logic [7:0] lk_addr;
  logic       busy, cfg_err, lk_ready;
  logic [1:0] rsp_valid, rsp_err;
  logic [5:0] rsp_dir;

  logic       init_req3, init_mode3, cfg_we3;
  logic [3:0] cfg_addr3;
  logic [2:0] cfg_data3;
  logic [1:0] lk_valid3;
  logic [7:0] lk_addr3;
  logic       busy3, cfg_err3, lk_ready3;
  logic [1:0] rsp_valid3, rsp_err3;
  logic [5:0] rsp_dir3;

  int tests = 0;
  int fails = 0;
  int n;

  typedef struct {
    int         which;
    int         port;
    logic [2:0] dir;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  routing_table_cfg #(.NODE_ID(5), .COLS(4), .ROWS(4)) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .init_mode(init_mode), .busy(busy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_dir(rsp_dir), .rsp_err(rsp_err)
  );

  routing_table_cfg #(.NODE_ID(5), .COLS(4), .ROWS(3)) dut3 (
    .clk(clk), .reset(reset), .init_req(init_req3), .init_mode(init_mode3), .busy(busy3),
    .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_data(cfg_data3), .cfg_err(cfg_err3),
    .lk_valid(lk_valid3), .lk_addr(lk_addr3), .lk_ready(lk_ready3),
    .rsp_valid(rsp_valid3), .rsp_dir(rsp_dir3), .rsp_err(rsp_err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int which, input int port, input logic [3:0] a,
                     input logic [2:0] d, input logic e);
    exp_t x;
    if (which == 0) begin
      lk_valid[port]        = 1'b1;
      lk_addr[port*4 +: 4]  = a;
    end else begin
      lk_valid3[port]       = 1'b1;
      lk_addr3[port*4 +: 4] = a;
    end
    x.which = which;
    x.port  = port;
    x.dir   = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic check_rsp();
    logic [1:0] m0, m1;
    exp_t x;
    m0 = '0;
    m1 = '0;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.which == 0) begin
        m0[x.port] = 1'b1;
        chk("rsp_dir", {29'd0, rsp_dir[x.port*3 +: 3]}, {29'd0, x.dir});
        chk("rsp_err", {31'd0, rsp_err[x.port]}, {31'd0, x.err});
      end else begin
        m1[x.port] = 1'b1;
        chk("rsp_dir3", {29'd0, rsp_dir3[x.port*3 +: 3]}, {29'd0, x.dir});
        chk("rsp_err3", {31'd0, rsp_err3[x.port]}, {31'd0, x.err});
      end
    end
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, m0});
    chk("rsp_valid3", {30'd0, rsp_valid3}, {30'd0, m1});
  endtask

  // Lookups are driven before the edge, cleared after it, then the registered responses are scored.
  task automatic lk_step();
    tick();
    lk_valid  = '0;
    lk_valid3 = '0;
    check_rsp();
  endtask

  task automatic wait_fill(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_init(input logic mode);
    init_req  = 1'b1;
    init_mode = mode;
    tick();
    init_req  = 1'b0;
    chk("busy_after_init", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    init_req = 0; init_mode = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    lk_valid = 0; lk_addr = 0;
    init_req3 = 0; init_mode3 = 0; cfg_we3 = 0; cfg_addr3 = 0; cfg_data3 = 0;
    lk_valid3 = 0; lk_addr3 = 0;
    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_lk_ready", {31'd0, lk_ready}, 32'd0);
    chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("reset_rsp_err", {30'd0, rsp_err}, 32'd0);

    reset = 1'b1;
    wait_fill(n);
    chk("fill_cycles", n, 32'd16);
    chk("lk_ready_run", {31'd0, lk_ready}, 32'd1);

    // XY routes from node 5
    req(0, 0, 4'd0, 3'd3, 1'b0);
    req(0, 1, 4'd13, 3'd2, 1'b0);
    lk_step();
    req(0, 0, 4'd5, 3'd4, 1'b0);
    req(0, 1, 4'd7, 3'd1, 1'b0);
    lk_step();

    // 3x4 mesh: 14 is out of range, 11 and 8 are valid
    req(1, 0, 4'd14, 3'd4, 1'b1);
    req(1, 1, 4'd11, 3'd1, 1'b0);
    lk_step();
    req(1, 0, 4'd8, 3'd3, 1'b0);
    lk_step();

    // YX refill with dropped lookups and a rejected write while busy
    do_init(1'b1);
    lk_valid = 2'b11;
    lk_addr  = 8'h00;
    lk_step();
    tick();
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 3'd2;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_busy", {31'd0, cfg_err}, 32'd1);
    tick();
    chk("cfg_err_pulse_end", {31'd0, cfg_err}, 32'd0);
    wait_fill(n);
    chk("yx_fill_cycles", n + 4, 32'd16);
    req(0, 0, 4'd0, 3'd0, 1'b0);
    req(0, 1, 4'd15, 3'd2, 1'b0);
    lk_step();
    req(0, 0, 4'd4, 3'd3, 1'b0);
    lk_step();

    // back to XY, then read-before-write on entry 10
    do_init(1'b0);
    wait_fill(n);
    chk("xy_fill_cycles", n, 32'd16);
    cfg_we = 1'b1; cfg_addr = 4'd10; cfg_data = 3'd0;
    req(0, 0, 4'd10, 3'd1, 1'b0);
    tick();
    cfg_we = 1'b0;
    lk_valid = '0;
    check_rsp();
    chk("cfg_err_good_write", {31'd0, cfg_err}, 32'd0);
    req(0, 0, 4'd10, 3'd0, 1'b0);
    lk_step();
    req(0, 0, 4'd10, 3'd0, 1'b0);
    req(0, 1, 4'd10, 3'd0, 1'b0);
    lk_step();

    // bad direction is rejected and leaves the entry alone
    cfg_we = 1'b1; cfg_addr = 4'd10; cfg_data = 3'd5;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_bad_data", {31'd0, cfg_err}, 32'd1);
    req(0, 0, 4'd10, 3'd0, 1'b0);
    lk_step();
    chk("cfg_err_bad_data_end", {31'd0, cfg_err}, 32'd0);

    // init_req and cfg_we together: write rejected, fill restarts
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 3'd4;
    init_req = 1'b1; init_mode = 1'b0;
    tick();
    cfg_we = 1'b0; init_req = 1'b0;
    chk("cfg_err_with_init", {31'd0, cfg_err}, 32'd1);
    chk("busy_with_init", {31'd0, busy}, 32'd1);
    wait_fill(n);
    chk("init_cfg_fill_cycles", n, 32'd16);
    req(0, 0, 4'd2, 3'd1, 1'b0);
    req(0, 1, 4'd10, 3'd1, 1'b0);
    lk_step();

    // async reset while a response and a cfg_err are showing
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 3'd7;
    req(0, 0, 4'd5, 3'd4, 1'b0);
    tick();
    cfg_we = 1'b0;
    lk_valid = '0;
    check_rsp();
    chk("cfg_err_before_reset", {31'd0, cfg_err}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("async_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b1;
    wait_fill(n);
    chk("refill_cycles", n, 32'd16);

    // reset at fill count 7 of a YX fill; restart comes back in XY
    do_init(1'b1);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b0;
    #1;
    chk("midfill_busy", {31'd0, busy}, 32'd1);
    chk("midfill_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    tick();
    reset = 1'b1;
    wait_fill(n);
    chk("midfill_refill_cycles", n, 32'd16);
    req(0, 0, 4'd0, 3'd3, 1'b0);
    req(0, 1, 4'd13, 3'd2, 1'b0);
    lk_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
